// File: rtl/lmc_pkg.sv
// Shared LMC definitions: default widths, opcode values and fetch FSM state encodings.
// Imported by the fetch unit, the decoder and the neighbouring loader/execute blocks.
package lmc_pkg;

    localparam int LMC_N   = 2;
    localparam int LMC_M   = 4;
    localparam int LMC_OPW = 2;

    localparam logic [1:0] OP_HLT = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_LDA = 2'b10;
    localparam logic [1:0] OP_BRA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_HALTED  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/lmc_decode.sv
// Combinational instruction splitter: opcode from the top OPW bits, operand from the rest,
// plus the two flags the fetch sequencer steers on.
module lmc_decode
    import lmc_pkg::*;
#(
    parameter int N   = LMC_N,
    parameter int M   = LMC_M,
    parameter int OPW = LMC_OPW
) (
    input  logic [M-1:0]   word,
    output logic [OPW-1:0] opcode,
    output logic [N-1:0]   operand,
    output logic           is_hlt,
    output logic           is_bra
);

    // Field split and opcode flags
    always_comb begin
        opcode  = word[M-1:M-OPW];
        operand = word[M-OPW-1:0];
        is_hlt  = (word[M-1:M-OPW] == OP_HLT);
        is_bra  = (word[M-1:M-OPW] == OP_BRA);
    end

endmodule

// File: rtl/lmc_fetch_unit.sv
// LMC fetch sequencer: addresses the program RAM from the PC, captures the word a cycle later,
// presents it to execute over valid/ready, and handles BRA redirect, HLT stop and PC loads.
module lmc_fetch_unit
    import lmc_pkg::*;
#(
    parameter int N   = LMC_N,
    parameter int M   = LMC_M,
    parameter int OPW = LMC_OPW
) (
    input  logic           timer555,
    input  logic           reset,
    input  logic           run,
    input  logic           pc_load,
    input  logic [N-1:0]   pc_load_value,
    output logic [N-1:0]   mem_adr,
    input  logic [M-1:0]   mem_data,
    output logic           instr_valid,
    input  logic           instr_ready,
    output logic [OPW-1:0] opcode,
    output logic [N-1:0]   operand,
    output logic           halted
);

    fetch_state_e   state_r;
    fetch_state_e   state_next_s;
    logic [N-1:0]   pc_r;
    logic [N-1:0]   pc_next_s;
    logic [M-1:0]   ir_r;
    logic [M-1:0]   ir_next_s;
    logic           capture_s;
    logic           is_hlt_r;
    logic [OPW-1:0] dec_opcode_s;
    logic [N-1:0]   dec_operand_s;
    logic           dec_is_hlt_s;
    logic           dec_is_bra_s;

    // The decoder sees the word that ir is about to hold, so CAPTURE can branch on fresh RAM data
    assign ir_next_s = capture_s ? mem_data : ir_r;

    lmc_decode #(.N(N), .M(M), .OPW(OPW)) u_decode (
        .word    (ir_next_s),
        .opcode  (dec_opcode_s),
        .operand (dec_operand_s),
        .is_hlt  (dec_is_hlt_s),
        .is_bra  (dec_is_bra_s)
    );

    // Next-state and PC logic; pc_load overrides the whole FSM
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        capture_s    = 1'b0;
        if (pc_load) begin
            state_next_s = S_IDLE;
            pc_next_s    = pc_load_value;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (run) begin
                        state_next_s = S_ADDR;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_ADDR: begin
                    state_next_s = S_CAPTURE;
                end
                S_CAPTURE: begin
                    capture_s    = 1'b1;
                    state_next_s = S_PRESENT;
                    if (dec_is_bra_s) begin
                        pc_next_s = dec_operand_s;
                    end else begin
                        pc_next_s = pc_r + {{(N-1){1'b0}}, 1'b1};
                    end
                end
                S_PRESENT: begin
                    if (instr_valid && instr_ready) begin
                        if (is_hlt_r) begin
                            state_next_s = S_HALTED;
                        end else if (run) begin
                            state_next_s = S_ADDR;
                        end else begin
                            state_next_s = S_IDLE;
                        end
                    end else begin
                        state_next_s = S_PRESENT;
                    end
                end
                S_HALTED: begin
                    state_next_s = S_HALTED;
                end
                default: begin
                    state_next_s = S_IDLE;
                end
            endcase
        end
    end

    // FSM state and program counter registers
    always_ff @(posedge timer555) begin
        if (reset) begin
            state_r <= S_IDLE;
            pc_r    <= {N{1'b0}};
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
        end
    end

    // Registered outputs; ir resets to 0 which decodes as HLT, so is_hlt_r starts set to match
    always_ff @(posedge timer555) begin
        if (reset) begin
            mem_adr     <= {N{1'b0}};
            ir_r        <= {M{1'b0}};
            opcode      <= {OPW{1'b0}};
            operand     <= {N{1'b0}};
            is_hlt_r    <= 1'b1;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            mem_adr     <= pc_r;
            ir_r        <= ir_next_s;
            opcode      <= dec_opcode_s;
            operand     <= dec_operand_s;
            is_hlt_r    <= dec_is_hlt_s;
            instr_valid <= (state_next_s == S_PRESENT);
            halted      <= (state_next_s == S_HALTED);
        end
    end

endmodule

// File: tb/tb_lmc_fetch_unit.sv
// Directed bench for lmc_fetch_unit with a 4-word behavioural program RAM.
// Each scenario task drives its stimulus and checks outputs one step after the rising edge.
module tb_lmc_fetch_unit;

    logic       timer555;
    logic       reset;
    logic       run;
    logic       pc_load;
    logic [1:0] pc_load_value;
    logic [1:0] mem_adr;
    logic [3:0] mem_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] opcode;
    logic [1:0] operand;
    logic       halted;

    logic [3:0] ram [4];
    int total = 0;
    int bad   = 0;

    assign mem_data = ram[mem_adr];

    lmc_fetch_unit dut (
        .timer555      (timer555),
        .reset         (reset),
        .run           (run),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem_adr       (mem_adr),
        .mem_data      (mem_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .operand       (operand),
        .halted        (halted)
    );

    initial timer555 = 1'b0;
    always #5 timer555 = ~timer555;

    task automatic tick();
        @(posedge timer555);
        #1;
    endtask

    // Advance until instr_valid is seen, at most 10 edges; n is the number of edges taken
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < 10);
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_load = 1'b1; pc_load_value = 2'd3;
        tick();
        reset = 1'b0; pc_load = 1'b0;
        total++; if (mem_adr !== 2'd0)     begin bad++; $display("FAIL reset_mem_adr got=%0d exp=0", mem_adr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        total++; if (opcode !== 2'd0)      begin bad++; $display("FAIL reset_opcode got=%0d exp=0", opcode); end
        total++; if (operand !== 2'd0)     begin bad++; $display("FAIL reset_operand got=%0d exp=0", operand); end
        total++; if (halted !== 1'b0)      begin bad++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    endtask

    task automatic test_fetch_loop();
        logic [1:0] exp_op  [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
        logic [1:0] exp_opd [5] = '{2'd1,  2'd1,  2'd2,  2'd2,  2'd2};
        int n;
        ram[0] = 4'h5; ram[1] = 4'h9; ram[2] = 4'hE; ram[3] = 4'h0;
        run = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(n);
            total++; if (n !== 3) begin bad++; $display("FAIL loop_latency[%0d] got=%0d exp=3", i, n); end
            total++; if (opcode !== exp_op[i] || operand !== exp_opd[i]) begin
                bad++; $display("FAIL loop_instr[%0d] got=%0d/%0d exp=%0d/%0d", i, opcode, operand, exp_op[i], exp_opd[i]);
            end
            total++; if (halted !== 1'b0) begin bad++; $display("FAIL loop_halted[%0d] got=%0b exp=0", i, halted); end
        end
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_halt();
        int n;
        pc_load = 1'b1; pc_load_value = 2'd0;
        tick();
        pc_load = 1'b0;
        ram[0] = 4'h4; ram[1] = 4'h0;
        run = 1'b1; instr_ready = 1'b1;
        wait_valid(n);
        total++; if (n !== 3 || opcode !== 2'b01 || operand !== 2'd0) begin
            bad++; $display("FAIL halt_add got=n%0d %0d/%0d exp=n3 1/0", n, opcode, operand);
        end
        wait_valid(n);
        total++; if (n !== 3 || opcode !== 2'b00) begin
            bad++; $display("FAIL halt_hlt got=n%0d op%0d exp=n3 op0", n, opcode);
        end
        tick();
        total++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL halt_enter got=h%0b v%0b exp=h1 v0", halted, instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (mem_adr !== 2'd2 || instr_valid !== 1'b0 || halted !== 1'b1) begin
                bad++; $display("FAIL halt_frozen[%0d] got=a%0d v%0b h%0b exp=a2 v0 h1", i, mem_adr, instr_valid, halted);
            end
        end
        run = 1'b0;
        pc_load = 1'b1; pc_load_value = 2'd0;
        tick();
        pc_load = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_release got=%0b exp=0", halted); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_idle[%0d] got=%0b exp=0", i, instr_valid); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        ram[0] = 4'h5; ram[1] = 4'h9;
        run = 1'b1; instr_ready = 1'b0;
        wait_valid(n);
        total++; if (n !== 3 || opcode !== 2'b01 || operand !== 2'd1) begin
            bad++; $display("FAIL bp_first got=n%0d %0d/%0d exp=n3 1/1", n, opcode, operand);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (instr_valid !== 1'b1 || opcode !== 2'b01 || operand !== 2'd1 || mem_adr !== 2'd1) begin
                bad++; $display("FAIL bp_hold[%0d] got=v%0b %0d/%0d a%0d exp=v1 1/1 a1", i, instr_valid, opcode, operand, mem_adr);
            end
        end
        instr_ready = 1'b1;
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL bp_single got=%0b exp=0", instr_valid); end
        wait_valid(n);
        total++; if (n !== 2 || opcode !== 2'b10 || operand !== 2'd1) begin
            bad++; $display("FAIL bp_next got=n%0d %0d/%0d exp=n2 2/1", n, opcode, operand);
        end
        run = 1'b0;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        ram[3] = 4'hA;
        pc_load = 1'b1; pc_load_value = 2'd3;
        tick();
        pc_load = 1'b0;
        run = 1'b1; instr_ready = 1'b0;
        wait_valid(n);
        total++; if (n !== 3 || opcode !== 2'b10 || operand !== 2'd2) begin
            bad++; $display("FAIL wrap_lda got=n%0d %0d/%0d exp=n3 2/2", n, opcode, operand);
        end
        tick();
        total++; if (mem_adr !== 2'd0) begin bad++; $display("FAIL wrap_adr got=%0d exp=0", mem_adr); end
        run = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
    endtask

    task automatic test_load_in_capture();
        int n;
        ram[0] = 4'hF; ram[1] = 4'h9;
        run = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        pc_load = 1'b1; pc_load_value = 2'd1;
        tick();
        pc_load = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL cap_drop got=%0b exp=0", instr_valid); end
        tick();
        total++; if (mem_adr !== 2'd1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL cap_adr got=a%0d v%0b exp=a1 v0", mem_adr, instr_valid);
        end
        wait_valid(n);
        total++; if (n !== 2 || opcode !== 2'b10 || operand !== 2'd1) begin
            bad++; $display("FAIL cap_next got=n%0d %0d/%0d exp=n2 2/1", n, opcode, operand);
        end
        run = 1'b0;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_over_load();
        int n;
        run = 1'b1; instr_ready = 1'b0;
        wait_valid(n);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b exp=1", instr_valid); end
        reset = 1'b1; pc_load = 1'b1; pc_load_value = 2'd3;
        tick();
        reset = 1'b0; pc_load = 1'b0; run = 1'b0;
        total++; if (instr_valid !== 1'b0 || opcode !== 2'd0 || operand !== 2'd0 || halted !== 1'b0 || mem_adr !== 2'd0) begin
            bad++; $display("FAIL rst_outputs got=v%0b %0d/%0d h%0b a%0d exp=v0 0/0 h0 a0", instr_valid, opcode, operand, halted, mem_adr);
        end
        tick();
        total++; if (mem_adr !== 2'd0) begin bad++; $display("FAIL rst_pc got=%0d exp=0", mem_adr); end
        run = 1'b1;
        wait_valid(n);
        total++; if (n !== 3 || opcode !== 2'b11 || operand !== 2'd3) begin
            bad++; $display("FAIL rst_fetch0 got=n%0d %0d/%0d exp=n3 3/3", n, opcode, operand);
        end
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; pc_load = 1'b0; pc_load_value = 2'd0; instr_ready = 1'b0;
        ram[0] = 4'h0; ram[1] = 4'h0; ram[2] = 4'h0; ram[3] = 4'h0;
        tick();
        test_reset();
        test_fetch_loop();
        test_halt();
        test_backpressure();
        test_wrap();
        test_load_in_capture();
        test_reset_over_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
